fetch_controller: RTL

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_perf_counter.sv | 40 ++++
 rtl/fetch_controller.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction fetch controller.
package fetch_pkg;

  localparam int DEFAULT_ADDR_W   = 8;
  localparam int DEFAULT_PROG_LEN = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_perf_counter.sv
// Saturating fetch/stall performance counters, cleared whenever a new run starts.
module fetch_perf_counter (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        fetch_inc,
  input  logic        stall_inc,
  output logic [15:0] fetch_cnt,
  output logic [15:0] stall_cnt
);

  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (clear) begin
      fetch_cnt_d = '0;
      stall_cnt_d = '0;
    end else begin
      if (fetch_inc && (fetch_cnt_q != 16'hFFFF)) fetch_cnt_d = fetch_cnt_q + 16'd1;
      if (stall_inc && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller driving a registered (1-cycle latency) instruction memory.
// Optional performance counters are built only when FETCH_PERF_EN is defined.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int PROG_LEN = DEFAULT_PROG_LEN
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic [7:0]        instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              halted,
  output logic              addr_err,
  output logic [15:0]       fetch_cnt,
  output logic [15:0]       stall_cnt
);

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);

  fetch_state_t      state_q, state_d;
  logic              resp_valid_q, resp_valid_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              addr_err_q, addr_err_d;

  // resp_* tracks the word returning from memory this cycle; fetch_pc is the address
  // issued in a bubble cycle (run entry or after a redirect squash).
  always_comb begin
    state_d      = state_q;
    resp_valid_d = resp_valid_q;
    resp_pc_d    = resp_pc_q;
    fetch_pc_d   = fetch_pc_q;
    addr_err_d   = addr_err_q;
    mem_addr     = '0;
    case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d      = RUN;
          resp_valid_d = 1'b0;
          fetch_pc_d   = '0;
        end
      end
      RUN: begin
        if (redirect_valid) begin
          resp_valid_d = 1'b0;
          if (redirect_addr > LAST_PC) begin
            addr_err_d = 1'b1;
            state_d    = HALT;
          end else begin
            fetch_pc_d = redirect_addr;
          end
        end else if (!resp_valid_q) begin
          mem_addr     = fetch_pc_q;
          resp_valid_d = 1'b1;
          resp_pc_d    = fetch_pc_q;
        end else if (!instr_ready) begin
          mem_addr = resp_pc_q;
        end else if (resp_pc_q == LAST_PC) begin
          state_d      = HALT;
          resp_valid_d = 1'b0;
        end else begin
          mem_addr  = resp_pc_q + ADDR_W'(1);
          resp_pc_d = resp_pc_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d      = IDLE;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      resp_valid_q <= 1'b0;
      resp_pc_q    <= '0;
      fetch_pc_q   <= '0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_pc_q    <= resp_pc_d;
      fetch_pc_q   <= fetch_pc_d;
      addr_err_q   <= addr_err_d;
    end
  end

  assign instr       = mem_data;
  assign instr_pc    = resp_pc_q;
  assign instr_valid = resp_valid_q;
  assign halted      = (state_q == HALT);
  assign addr_err    = addr_err_q;

`ifdef FETCH_PERF_EN
  logic perf_clear, perf_fetch, perf_stall;

  // A squashing redirect neither transfers the word nor counts as a stall.
  assign perf_clear = (state_q != RUN) && start;
  assign perf_fetch = (state_q == RUN) && resp_valid_q && instr_ready && !redirect_valid;
  assign perf_stall = (state_q == RUN) && resp_valid_q && !instr_ready && !redirect_valid;

  fetch_perf_counter u_perf (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (perf_clear),
    .fetch_inc (perf_fetch),
    .stall_inc (perf_stall),
    .fetch_cnt (fetch_cnt),
    .stall_cnt (stall_cnt)
  );
`else
  assign fetch_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule
